// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the key conditioner: keypad FSM state encoding,
// key counts, raw-input bit positions and small keypad helper functions.
package key_conditioner_pkg;

    localparam int NKEYS       = 10;
    localparam int NRAW        = NKEYS + 2;
    localparam int BIT_MODE    = NKEYS;
    localparam int BIT_SETTING = NKEYS + 1;

    typedef enum logic [1:0] {
        KS_IDLE = 2'd0,
        KS_HELD = 2'd1,
        KS_LOCK = 2'd2
    } key_state_t;

    // True when exactly one keypad line is active.
    function automatic logic is_onehot(input logic [NKEYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Index of the lowest active line; only meaningful for a one-hot vector.
    function automatic logic [3:0] bcd_encode(input logic [NKEYS-1:0] v);
        logic [3:0] d;
        d = 4'd0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                d = 4'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/key_conditioner_debounce_cell.sv
// One raw switch input: 2-flop synchroniser, stability counter, debounced
// level flop and a registered one-cycle pulse on each debounced 0->1 edge.
module debounce_cell
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic [CW-1:0] cnt_reg;
    logic          deb_reg;
    logic          deb_prev_reg;
    logic          rise_reg;

    // Synchronise, count disagreement run length, flip once it is long enough.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            cnt_reg      <= '0;
            deb_reg      <= 1'b0;
            deb_prev_reg <= 1'b0;
            rise_reg     <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg == deb_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_reg <= '0;
                deb_reg <= sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            deb_prev_reg <= deb_reg;
            rise_reg     <= deb_reg & ~deb_prev_reg;
        end
    end

    assign level = deb_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/key_conditioner.sv
// Key conditioner top: debounces the mode/setting buttons and the 10-line
// digit keypad, and turns the keypad into BCD digit / error strobes.
// Optional feature macro KEY_REPEAT_EN: auto-repeat of a held single digit.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20,
    parameter int REPEAT_DLY   = 500,
    parameter int REPEAT_PER   = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_raw,
    input  logic             setting_raw,
    input  logic [NKEYS-1:0] keypad_raw,
    output logic             mode_btn,
    output logic             setting_btn,
    output logic             key_valid,
    output logic [3:0]       key_digit,
    output logic             key_error
);

    logic [NRAW-1:0]  raw_vec;
    logic [NRAW-1:0]  deb_vec;
    logic [NRAW-1:0]  rise_vec;
    logic [NKEYS-1:0] kd;
    logic [NKEYS-1:0] held_vec;

    key_state_t state_reg;
    logic       key_valid_reg;
    logic       key_error_reg;
    logic [3:0] key_digit_reg;

    assign raw_vec = {setting_raw, mode_raw, keypad_raw};

    genvar gi;
    generate
        for (gi = 0; gi < NRAW; gi++) begin : g_cell
            debounce_cell #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_cell (
                .clk  (clk),
                .rst  (rst),
                .raw  (raw_vec[gi]),
                .level(deb_vec[gi]),
                .rise (rise_vec[gi])
            );
        end
    endgenerate

    assign kd       = deb_vec[NKEYS-1:0];
    assign held_vec = {{(NKEYS-1){1'b0}}, 1'b1} << key_digit_reg;

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW      = $clog2(REP_MAX + 1);

    logic [RW-1:0] rep_cnt_reg;
    logic          rep_first_reg;
    logic [RW-1:0] rep_last;

    // First repeat waits the long delay, later ones the shorter period.
    assign rep_last = rep_first_reg ? RW'(REPEAT_DLY - 1) : RW'(REPEAT_PER - 1);
`endif

    // Keypad FSM: one strobe per clean press, lock out chords until all keys are up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= KS_IDLE;
            key_valid_reg <= 1'b0;
            key_error_reg <= 1'b0;
            key_digit_reg <= 4'd0;
`ifdef KEY_REPEAT_EN
            rep_cnt_reg   <= '0;
            rep_first_reg <= 1'b0;
`endif
        end else begin
            key_valid_reg <= 1'b0;
            key_error_reg <= 1'b0;
            case (state_reg)
                KS_IDLE: begin
                    if (is_onehot(kd)) begin
                        key_valid_reg <= 1'b1;
                        key_digit_reg <= bcd_encode(kd);
                        state_reg     <= KS_HELD;
`ifdef KEY_REPEAT_EN
                        rep_cnt_reg   <= '0;
                        rep_first_reg <= 1'b1;
`endif
                    end else if (kd != '0) begin
                        key_error_reg <= 1'b1;
                        state_reg     <= KS_LOCK;
                    end
                end
                KS_HELD: begin
                    // Any change away from the held digit (extra or swapped key) locks out.
                    if (kd == '0) begin
                        state_reg <= KS_IDLE;
                    end else if (kd != held_vec) begin
                        state_reg <= KS_LOCK;
                    end
`ifdef KEY_REPEAT_EN
                    if (kd == held_vec) begin
                        if (rep_cnt_reg == rep_last) begin
                            key_valid_reg <= 1'b1;
                            rep_cnt_reg   <= '0;
                            rep_first_reg <= 1'b0;
                        end else begin
                            rep_cnt_reg <= rep_cnt_reg + 1'b1;
                        end
                    end else begin
                        rep_cnt_reg   <= '0;
                        rep_first_reg <= 1'b0;
                    end
`endif
                end
                KS_LOCK: begin
                    if (kd == '0) begin
                        state_reg <= KS_IDLE;
                    end
                end
                default: begin
                    state_reg <= KS_IDLE;
                end
            endcase
        end
    end

    assign mode_btn    = rise_vec[BIT_MODE];
    assign setting_btn = rise_vec[BIT_SETTING];
    assign key_valid   = key_valid_reg;
    assign key_error   = key_error_reg;
    assign key_digit   = key_digit_reg;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random
// keypad/button activity, checked every cycle against a behavioural model.
module tb_key_conditioner;

    localparam int D    = 20;
    localparam int RDLY = 500;
    localparam int RPER = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode_raw = 1'b0;
    logic       setting_raw = 1'b0;
    logic [9:0] keypad_raw = '0;
    logic       mode_btn;
    logic       setting_btn;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       key_error;

    always #5 clk = ~clk;

    key_conditioner #(
        .DEBOUNCE_CYC(D),
        .REPEAT_DLY  (RDLY),
        .REPEAT_PER  (RPER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_raw   (mode_raw),
        .setting_raw(setting_raw),
        .keypad_raw (keypad_raw),
        .mode_btn   (mode_btn),
        .setting_btn(setting_btn),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_error  (key_error)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw samples taken at each clock edge since reset release, bit order
    // {setting, mode, keypad[9:0]}. A debounced bit flips at edge m when the
    // raw samples at edges m-2-D+1 .. m-2 all disagree with it.
    logic [11:0] hist[$];
    logic [11:0] m_deb, m_d1, m_d2;
    int          m_state;   // 0 idle, 1 held, 2 locked out
    int          m_digit;
    int          m_edge;
    int          m_t0;

    // per-phase observations of the DUT
    int k;
    int cnt_mode, cnt_set, cnt_val, cnt_err;
    int first_mode, first_set, first_err;
    int val_at[$];

    function automatic logic raw_bit(input int e, input int i);
        if (e < 1) return 1'b0;
        return hist[e-1][i];
    endfunction

    task automatic model_clear();
        hist.delete();
        m_deb = '0; m_d1 = '0; m_d2 = '0;
        m_state = 0; m_digit = 0; m_edge = 0; m_t0 = 0;
    endtask

    task automatic phase_start();
        k = 0;
        cnt_mode = 0; cnt_set = 0; cnt_val = 0; cnt_err = 0;
        first_mode = -1; first_set = -1; first_err = -1;
        val_at.delete();
    endtask

    task automatic set_raw(input logic m, input logic s, input logic [9:0] kp);
        mode_raw = m; setting_raw = s; keypad_raw = kp;
    endtask

    task automatic step();
        logic [11:0] rawv;
        logic [11:0] nd;
        logic [9:0]  kd;
        logic        e_mode, e_set, e_val, e_err;
        logic        flip;
        int          dt;
        rawv = {setting_raw, mode_raw, keypad_raw};
        @(posedge clk);
        #1;
        k++;
        if (!rst) begin
            model_clear();
            check("reset_outputs", {24'd0, mode_btn, setting_btn, key_valid, key_error, key_digit}, 32'd0);
            return;
        end
        hist.push_back(rawv);
        m_edge++;
        nd = m_deb;
        for (int i = 0; i < 12; i++) begin
            flip = 1'b1;
            for (int j = 0; j < D; j++) begin
                if (raw_bit(m_edge - 2 - j, i) == m_deb[i]) flip = 1'b0;
            end
            if (flip) nd[i] = ~m_deb[i];
        end
        m_d2 = m_d1; m_d1 = m_deb; m_deb = nd;
        e_mode = m_d1[10] & ~m_d2[10];
        e_set  = m_d1[11] & ~m_d2[11];
        e_val  = 1'b0;
        e_err  = 1'b0;
        kd     = m_d1[9:0];
        case (m_state)
            0: begin
                if ($countones(kd) == 1) begin
                    e_val = 1'b1;
                    for (int i = 0; i < 10; i++) if (kd[i]) m_digit = i;
                    m_state = 1;
                    m_t0 = m_edge;
                end else if (kd != 0) begin
                    e_err = 1'b1;
                    m_state = 2;
                end
            end
            1: begin
                if (kd == 0) m_state = 0;
                else if (kd != (10'd1 << m_digit)) m_state = 2;
`ifdef KEY_REPEAT_EN
                else begin
                    dt = m_edge - m_t0;
                    if (dt == RDLY || (dt > RDLY && (dt - RDLY) % RPER == 0)) e_val = 1'b1;
                end
`endif
            end
            default: begin
                if (kd == 0) m_state = 0;
            end
        endcase
        dt = 0;
        check("cycle", {24'd0, mode_btn, setting_btn, key_valid, key_error, key_digit},
              {24'd0, e_mode, e_set, e_val, e_err, 4'(m_digit)});
        if (mode_btn)    begin cnt_mode++; if (first_mode < 0) first_mode = k; end
        if (setting_btn) begin cnt_set++;  if (first_set  < 0) first_set  = k; end
        if (key_error)   begin cnt_err++;  if (first_err  < 0) first_err  = k; end
        if (key_valid)   begin cnt_val++;  val_at.push_back(k); end
        if (mode_btn || setting_btn || key_valid || key_error)
            $display("txn t=%0t mode=%0b setting=%0b valid=%0b digit=%0d error=%0b",
                     $time, mode_btn, setting_btn, key_valid, key_digit, key_error);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int dur, r;
        logic [9:0] kp;
        model_clear();
        phase_start();

        // Reset with every raw input held high
        rst = 1'b0;
        set_raw(1'b1, 1'b1, 10'h3FF);
        #1;
        check("reset_async", {24'd0, mode_btn, setting_btn, key_valid, key_error, key_digit}, 32'd0);
        run(3);
        rst = 1'b1;
        phase_start();
        run(30);
        check("rel_mode_cnt", cnt_mode, 1);
        check("rel_mode_at", first_mode, 23);
        check("rel_set_cnt", cnt_set, 1);
        check("rel_set_at", first_set, 23);
        check("rel_err_cnt", cnt_err, 1);
        check("rel_err_at", first_err, 23);
        check("rel_val_cnt", cnt_val, 0);
        set_raw(1'b0, 1'b0, 10'h000);
        run(30);

        // Glitch shorter than the debounce window
        phase_start();
        set_raw(1'b1, 1'b0, 10'h000); run(15);
        set_raw(1'b0, 1'b0, 10'h000); run(30);
        check("glitch_mode_cnt", cnt_mode, 0);

        // Held button: one pulse, no pulse on release
        phase_start();
        set_raw(1'b1, 1'b0, 10'h000); run(40);
        set_raw(1'b0, 1'b0, 10'h000); run(30);
        check("held_mode_cnt", cnt_mode, 1);
        check("held_mode_at", first_mode, 23);

        // Single digit 5
        phase_start();
        set_raw(1'b0, 1'b0, 10'b00_0010_0000); run(50);
        set_raw(1'b0, 1'b0, 10'h000); run(30);
        check("digit5_val_cnt", cnt_val, 1);
        check("digit5_val_at", (val_at.size() > 0) ? val_at[0] : -1, 23);
        check("digit5_err_cnt", cnt_err, 0);
        check("digit5_hold", key_digit, 5);

        // Two keys together -> error only, then digit 3
        phase_start();
        set_raw(1'b0, 1'b0, 10'b00_1000_0100); run(40);
        set_raw(1'b0, 1'b0, 10'h000); run(30);
        check("multi_err_cnt", cnt_err, 1);
        check("multi_val_cnt", cnt_val, 0);
        phase_start();
        set_raw(1'b0, 1'b0, 10'b00_0000_1000); run(40);
        set_raw(1'b0, 1'b0, 10'h000); run(30);
        check("after_multi_val_cnt", cnt_val, 1);
        check("after_multi_digit", key_digit, 3);

        // Rollover: 1 held, add 4, drop 1, release, press 4
        phase_start();
        set_raw(1'b0, 1'b0, 10'b00_0000_0010); run(40);
        check("roll1_val_cnt", cnt_val, 1);
        check("roll1_digit", key_digit, 1);
        phase_start();
        set_raw(1'b0, 1'b0, 10'b00_0001_0010); run(40);
        set_raw(1'b0, 1'b0, 10'b00_0001_0000); run(40);
        check("roll_val_cnt", cnt_val, 0);
        check("roll_err_cnt", cnt_err, 0);
        set_raw(1'b0, 1'b0, 10'h000); run(40);
        phase_start();
        set_raw(1'b0, 1'b0, 10'b00_0001_0000); run(40);
        set_raw(1'b0, 1'b0, 10'h000); run(30);
        check("roll4_val_cnt", cnt_val, 1);
        check("roll4_digit", key_digit, 4);

        // Reset in the middle of a debounce discards the event
        phase_start();
        set_raw(1'b1, 1'b0, 10'h000); run(10);
        rst = 1'b0;
        #1;
        check("midrst_async", {24'd0, mode_btn, setting_btn, key_valid, key_error, key_digit}, 32'd0);
        run(2);
        rst = 1'b1;
        set_raw(1'b0, 1'b0, 10'h000); run(30);
        check("midrst_mode_cnt", cnt_mode, 0);

        // Long hold of digit 9
        phase_start();
        set_raw(1'b0, 1'b0, 10'b10_0000_0000); run(1000);
        set_raw(1'b0, 1'b0, 10'h000); run(30);
`ifdef KEY_REPEAT_EN
        check("hold9_val_cnt", cnt_val, 4);
        check("hold9_at0", (val_at.size() > 0) ? val_at[0] : -1, 23);
        check("hold9_at1", (val_at.size() > 1) ? val_at[1] : -1, 523);
        check("hold9_at2", (val_at.size() > 2) ? val_at[2] : -1, 723);
        check("hold9_at3", (val_at.size() > 3) ? val_at[3] : -1, 923);
`else
        check("hold9_val_cnt", cnt_val, 1);
        check("hold9_at0", (val_at.size() > 0) ? val_at[0] : -1, 23);
`endif
        check("hold9_digit", key_digit, 9);

        // Random activity, model-checked every cycle
        for (int seg = 0; seg < 80; seg++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      kp = 10'h000;
            else if (r < 70) kp = 10'd1 << $urandom_range(0, 9);
            else if (r < 85) kp = 10'($urandom_range(1, 1023));
            else             kp = 10'h000;
            set_raw(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), kp);
            dur = $urandom_range(3, 50);
            run(dur);
        end
        set_raw(1'b0, 1'b0, 10'h000);
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
